// File: rtl/regfile_pkg.sv
// Shared constants and soft-clear state encoding for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefNumRd     = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks every register address once, then pulses clr_done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  clear_en,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;
    logic                  done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (clr_req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    // Requests here are intentionally dropped, not queued.
                    if (cnt_q == LastAddr) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy   = busy_q;
    assign clr_done   = done_q;
    assign clear_en   = (state_q == StClear);
    assign clear_addr = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port register file with pending-write scoreboard and soft clear.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_RD     = DefNumRd,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]        wd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         alloc_valid,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pend_q;

    logic                  clear_en;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  wr_ok;
    logic                  alloc_ok;

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clear_en   (clear_en),
        .clear_addr (clear_addr)
    );

    assign wr_ok    = we && !clr_busy && !((ZERO_REG != 0) && (wa == '0));
    assign alloc_ok = alloc_valid && !clr_busy && !((ZERO_REG != 0) && (alloc_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clear_en && (clear_addr == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= '0;
                end else if (wr_ok && (wa == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= wd;
                end
            end
        end
    end

    // Allocation outranks a same-cycle write: the newer producer keeps the entry pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clear_en && (clear_addr == ADDR_WIDTH'(i))) begin
                    pend_q[i] <= 1'b0;
                end else if (alloc_ok && (alloc_addr == ADDR_WIDTH'(i))) begin
                    pend_q[i] <= 1'b1;
                end else if (wr_ok && (wa == ADDR_WIDTH'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_g;
        logic                  zero_hit;
        logic                  byp_hit;

        assign ra_g     = ra[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = (ZERO_REG != 0) && (ra_g == '0);
        assign byp_hit  = (BYPASS != 0) && wr_ok && (wa == ra_g);

        assign rd[g*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 :
                                                byp_hit  ? wd : regs_q[ra_g];
        assign rd_busy[g] = !zero_hit && pend_q[ra_g] && !byp_hit;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the single-cycle 32x32 register file. It supports a configurable depth, width and number of read ports, plus optional write-to-read bypass and an optional hardwired-zero register 0. It adds a per-register pending-write scoreboard and a sequenced soft-clear engine. It sits in the datapath of the upcoming pipelined core, between decode (reads, allocation) and writeback (write port).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and allocations

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
we  in  1  write enable (writeback)
wa  in  ADDR_WIDTH  write address
wd  in  DATA_WIDTH  write data
ra  in  NUM_RD*ADDR_WIDTH  read addresses; port i = ra[i*ADDR_WIDTH +: ADDR_WIDTH]
rd  out  NUM_RD*DATA_WIDTH  read data, combinational; port i = rd[i*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_RD  1 = register on port i has an outstanding producer
alloc_valid  in  1  mark alloc_addr as pending (instruction issued with destination)
alloc_addr  in  ADDR_WIDTH  destination being allocated
clr_req  in  1  start soft clear of all registers and scoreboard
clr_busy  out  1  soft clear in progress
clr_done  out  1  one-cycle pulse when soft clear completes

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
- rst low (any time, including mid-clear):
  - All registers = 0, all pend bits = 0, FSM = IDLE, counter = 0.
  - Outputs: clr_busy = 0, clr_done = 0, rd_busy = 0, rd reflects zeroed storage.
- Write:
  - At the rising edge, reg[wa] <= wd when we=1 and clr_busy=0 and not (ZERO_REG=1 and wa=0).
  - Writes while clr_busy=1 are dropped.
- Read (combinational, zero latency), port i:
  - If ZERO_REG=1 and ra_i=0, rd_i = 0.
  - Else if BYPASS=1 and a write is qualified this cycle (per Write rule) and wa = ra_i, rd_i = wd. This is the bypass hit.
  - Else rd_i = reg[ra_i].
  - All ports are independent. Any number of ports may share an address.
- Scoreboard pend[DEPTH]:
  - Set on a rising edge when alloc_valid=1, clr_busy=0 and not (ZERO_REG=1 and alloc_addr=0).
  - Cleared on a qualified write to that address.
  - Alloc and write to the same address in the same cycle: pend stays 1 (the new producer wins).
  - Alloc and write to different addresses: both take effect.
  - rd_busy_i = pend[ra_i] AND NOT bypass_hit_i. With ZERO_REG=1 and ra_i=0, rd_busy_i = 0.
- Soft-clear FSM:
  - States IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req=1; counter = 0.
  - In CLEAR, each cycle: reg[counter] <= 0, pend[counter] <= 0, counter++. clr_busy = 1.
  - After counter = DEPTH-1 is cleared -> DONE.
  - In DONE: clr_done = 1 for exactly one cycle, clr_busy = 0, then -> IDLE.
  - Total: DEPTH cycles busy, done pulse on cycle DEPTH+1 after the request edge.
  - clr_req while in CLEAR or DONE is ignored (not queued).
  - Reads during CLEAR return current storage, a mix of cleared and uncleared registers. Consumers must wait for clr_busy=0.
  - Counter width = ADDR_WIDTH; it wraps only via the state transition, never by overflow.
- Widths: addresses are unsigned. There is no arithmetic on data.

Decomposition:
- Package regfile_pkg: FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and default width/depth constants shared with the core top.
- One sub-module, regfile_clear_fsm: owns state, counter, clr_busy and clr_done. It outputs clear_en and clear_addr to the storage and scoreboard.
- Read ports are generated by a generate loop over NUM_RD. There is no per-port sub-module.

Test Plan:
- Reset: drive rst=0 mid-operation with reg5 = 0xDEADBEEF and pend5 = 1 -> all rd = 0, rd_busy = 0, clr_busy = 0 immediately, without waiting for a clock edge.
- Write and read: we=1, wa=7, wd=0x12345678; next cycle ra0=7, ra1=7 -> both rd = 0x12345678. Same cycle with BYPASS=1 -> rd = 0x12345678 combinationally; with BYPASS=0 -> old value 0.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF and alloc_addr=0 -> rd for ra=0 stays 0, rd_busy = 0. With ZERO_REG=0 -> reads 0xFFFFFFFF.
- Scoreboard:
  - alloc_addr=3 at cycle 1 -> rd_busy = 1 for ra=3 from cycle 2.
  - we=1, wa=3 at cycle 4 -> rd_busy = 0 in cycle 4 (bypass hit) and afterwards.
  - Simultaneous alloc and write to addr 3 -> busy remains 1.
- Soft clear: load regs 1..31 with nonzero values, pulse clr_req:
  - clr_busy high for 32 cycles, then clr_done high for exactly 1 cycle; all regs and pend = 0.
  - A write to reg 9 at clear cycle 20 is dropped (reg 9 = 0 afterwards).
  - A second clr_req during CLEAR does not extend clr_busy.
- Reset mid-clear: rst=0 at clear cycle 10 -> clr_busy = 0 immediately, no clr_done pulse, all regs = 0. A new clr_req after reset completes normally in 32 cycles.
